// File: rtl/egd_pkg.sv
// Shared constants for the streaming Exp-Golomb decoder: request modes, FSM states
// and the fill_level width helper.
package egd_pkg;

    localparam logic [1:0] EGD_UE  = 2'b00;
    localparam logic [1:0] EGD_SE  = 2'b01;
    localparam logic [1:0] EGD_TE  = 2'b10;
    localparam logic [1:0] EGD_RAW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } egd_state_e;

    function automatic int egd_fill_w(input int buf_w);
        return $clog2(buf_w + 1);
    endfunction

endpackage

// File: rtl/egd_lzc.sv
// Leading-zero counter over the top 2*MAX_LZ+1 buffer bits; the count never
// exceeds the number of valid bits, so lz < fill means a marker bit was seen.
module egd_lzc import egd_pkg::*; #(
    parameter int BUF_W  = 32,
    parameter int MAX_LZ = 15
) (
    input  logic [2*MAX_LZ:0]              win,
    input  logic [egd_fill_w(BUF_W)-1:0]   fill,
    output logic [egd_fill_w(BUF_W)-1:0]   lz
);
    localparam int FW  = egd_fill_w(BUF_W);
    localparam int WIN = 2*MAX_LZ + 1;

    logic [FW-1:0] cnt;
    logic          found;

    always_comb begin
        cnt   = FW'(WIN);
        found = 1'b0;
        for (int i = WIN-1; i >= 0; i--) begin
            if (!found && win[i]) begin
                cnt   = FW'(WIN-1-i);
                found = 1'b1;
            end
        end
        lz = (cnt < fill) ? cnt : fill;
    end

endmodule

// File: rtl/egd_stream_dec.sv
// Streaming Exp-Golomb decoder: ue/se/te/raw elements from an MSB-first shift buffer.
// EGD_SIGNED_EN enables se/te decoding; without it those modes raise err on acceptance.
module egd_stream_dec import egd_pkg::*; #(
    parameter int IN_W   = 16,
    parameter int BUF_W  = 32,
    parameter int OUT_W  = 16,
    parameter int MAX_LZ = 15
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    input  logic [IN_W-1:0]               in_data,
    output logic                          in_ready,
    input  logic                          req_valid,
    input  logic [1:0]                    req_mode,
    input  logic                          req_te_max1,
    input  logic [4:0]                    req_len,
    output logic                          req_ready,
    output logic                          out_valid,
    output logic [OUT_W-1:0]              out_data,
    output logic [5:0]                    out_len,
    input  logic                          out_ready,
    input  logic                          flush,
    output logic                          err,
    output logic [egd_fill_w(BUF_W)-1:0]  fill_level
);
    localparam int FW  = egd_fill_w(BUF_W);
    localparam int WIN = 2*MAX_LZ + 1;
    localparam int CW  = MAX_LZ + 1;

    egd_state_e     state;
    logic [BUF_W-1:0] bits, bits_sh;
    logic [1:0]     mode_q;
    logic [4:0]     len_q;
    logic           te1_q;
    logic [FW-1:0]  lz, rem;
    int             lzi, fl, lz_c;
    logic [CW-1:0]  info, code;
    logic [15:0]    raw;
    logic           done, bad, fire, req_rej;
    logic [5:0]     clen;
    logic [OUT_W-1:0] val;

    egd_lzc #(.BUF_W(BUF_W), .MAX_LZ(MAX_LZ)) u_lzc (
        .win  (bits[BUF_W-1 -: WIN]),
        .fill (fill_level),
        .lz   (lz)
    );

    assign in_ready  = (int'(fill_level) <= BUF_W-IN_W) && !err;
    assign req_ready = (state == ST_IDLE);

`ifdef EGD_SIGNED_EN
    assign req_rej = (req_mode == EGD_RAW) && (req_len == 5'd0 || req_len > 5'd16);
`else
    assign req_rej = (req_mode == EGD_SE) || (req_mode == EGD_TE) ||
                     ((req_mode == EGD_RAW) && (req_len == 5'd0 || req_len > 5'd16));
`endif

    always_comb begin
        lzi  = int'(lz);
        fl   = int'(fill_level);
        lz_c = (lzi > MAX_LZ) ? MAX_LZ : lzi;
        // info field is the lz bits right after the marker 1
        info = CW'(bits[BUF_W-2-lz_c -: MAX_LZ] >> (MAX_LZ - lz_c));
        code = (CW'(1) << lz_c) - CW'(1) + info;
        raw  = bits[BUF_W-1 -: 16] >> (16 - int'(len_q));
        done = 1'b0;
        bad  = 1'b0;
        clen = '0;
        val  = '0;
        if (mode_q == EGD_RAW) begin
            done = int'(len_q) <= fl;
            clen = 6'(len_q);
            val  = OUT_W'(raw);
        end else if (mode_q == EGD_TE && te1_q) begin
            done = fl >= 1;
            clen = 6'd1;
`ifdef EGD_SIGNED_EN
            val  = OUT_W'(!bits[BUF_W-1]);
`endif
        end else begin
            bad  = lzi > MAX_LZ;
            done = (lzi < fl) && (2*lzi + 1 <= fl);
            clen = 6'(2*lz_c + 1);
            val  = OUT_W'(code);
`ifdef EGD_SIGNED_EN
            if (mode_q == EGD_SE)
                val = code[0] ? OUT_W'((code + CW'(1)) >> 1)
                              : OUT_W'(32'd0 - 32'(code >> 1));
`endif
        end
        fire = (state == ST_WAIT) && done && !bad && (!out_valid || out_ready);
    end

    // New words land directly below whatever survives this cycle's consume
    assign rem     = fill_level - (fire ? FW'(clen) : FW'(0));
    assign bits_sh = bits << (fire ? clen : 6'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bits       <= '0;
            fill_level <= '0;
        end else if (flush) begin
            bits       <= '0;
            fill_level <= '0;
        end else if (in_valid && in_ready) begin
            bits       <= bits_sh | ({in_data, {(BUF_W-IN_W){1'b0}}} >> rem);
            fill_level <= rem + FW'(IN_W);
        end else begin
            bits       <= bits_sh;
            fill_level <= rem;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
            err       <= 1'b0;
            mode_q    <= EGD_UE;
            len_q     <= '0;
            te1_q     <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
            err       <= 1'b0;
            mode_q    <= EGD_UE;
            len_q     <= '0;
            te1_q     <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                ST_IDLE: if (req_valid) begin
                    mode_q <= req_mode;
                    len_q  <= req_len;
                    te1_q  <= req_te_max1;
                    if (req_rej) begin
                        err   <= 1'b1;
                        state <= ST_ERR;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: if (bad) begin
                    err   <= 1'b1;
                    state <= ST_ERR;
                end else if (fire) begin
                    out_valid <= 1'b1;
                    out_data  <= val;
                    out_len   <= clen;
                    state     <= ST_IDLE;
                end
                ST_ERR: ;
                default: state <= ST_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_egd_stream_dec.sv
// Bench for egd_stream_dec: directed checks from the element table, then random
// traffic scored against a bit-queue reference decoder.
`timescale 1ns/1ps
module tb_egd_stream_dec;
    import egd_pkg::*;

    localparam int IN_W = 16, BUF_W = 32, OUT_W = 16, MAX_LZ = 15;

    logic clk = 1'b0, reset_n = 1'b0;
    logic in_valid = 1'b0, req_valid = 1'b0, req_te_max1 = 1'b0, out_ready = 1'b1, flush = 1'b0;
    logic [IN_W-1:0] in_data = '0;
    logic [1:0] req_mode = '0;
    logic [4:0] req_len = '0;
    logic in_ready, req_ready, out_valid, err;
    logic [OUT_W-1:0] out_data;
    logic [5:0] out_len;
    logic [5:0] fill_level;

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    egd_stream_dec #(.IN_W(IN_W), .BUF_W(BUF_W), .OUT_W(OUT_W), .MAX_LZ(MAX_LZ)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .req_valid(req_valid), .req_mode(req_mode), .req_te_max1(req_te_max1), .req_len(req_len),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_len(out_len),
        .out_ready(out_ready), .flush(flush), .err(err), .fill_level(fill_level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a plain bit stream and a queue of accepted requests
    typedef struct { logic [1:0] mode; logic te1; int len; } req_t;
    bit   bitq[$];
    req_t reqq[$];
    bit   mon_en = 1'b0;

    task automatic model_dec(input req_t r, output int v, output int l);
        int lz, info, k;
        v = 0;
        l = 0;
        if (r.mode == EGD_RAW) begin
            for (int i = 0; i < r.len; i++) v = v*2 + int'(bitq.pop_front());
            l = r.len;
        end else if (r.mode == EGD_TE && r.te1) begin
            v = bitq.pop_front() ? 0 : 1;
            l = 1;
        end else begin
            lz = 0;
            while (bitq.size() > 0 && bitq[0] == 1'b0) begin
                void'(bitq.pop_front());
                lz++;
            end
            void'(bitq.pop_front());
            info = 0;
            for (int i = 0; i < lz; i++) info = info*2 + int'(bitq.pop_front());
            k = (1 << lz) - 1 + info;
            l = 2*lz + 1;
            v = (r.mode == EGD_SE) ? ((k % 2 == 1) ? (k+1)/2 : -(k/2)) : k;
        end
        v = v & 32'hFFFF;
    endtask

    function automatic logic [15:0] gen_word();
        logic [15:0] w;
        w = 16'($urandom);
        w[15 - $urandom_range(0, 7)] = 1'b1;
        w[7 - $urandom_range(0, 7)]  = 1'b1;
        return w;
    endfunction

    initial begin : monitor
        req_t r;
        int ev, el;
        bit held;
        logic [OUT_W-1:0] held_d;
        logic [5:0] held_l;
        held = 1'b0;
        held_d = '0;
        held_l = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (held && out_valid) begin
                    chk("hold_data", 32'(out_data), 32'(held_d));
                    chk("hold_len", 32'(out_len), 32'(held_l));
                end
                if (in_valid && in_ready)
                    for (int i = IN_W-1; i >= 0; i--) bitq.push_back(in_data[i]);
                if (req_valid && req_ready)
                    reqq.push_back('{req_mode, req_te_max1, int'(req_len)});
                if (out_valid && out_ready) begin
                    if (reqq.size() == 0) begin
                        chk("spurious_out", 32'd1, 32'd0);
                    end else begin
                        r = reqq.pop_front();
                        model_dec(r, ev, el);
                        chk("rnd_data", 32'(out_data), ev);
                        chk("rnd_len", 32'(out_len), el);
                    end
                end
                held   = out_valid && !out_ready;
                held_d = out_data;
                held_l = out_len;
            end
        end
    end

    task automatic push(input logic [15:0] w);
        int n;
        in_valid = 1'b1;
        in_data  = w;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 50) chk("push_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic req(input logic [1:0] m, input logic t, input logic [4:0] n);
        int k;
        req_valid   = 1'b1;
        req_mode    = m;
        req_te_max1 = t;
        req_len     = n;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (k == 50) chk("req_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic get_out(output int v, output int l, output int w);
        v = -1;
        l = -1;
        for (w = 1; w <= 50; w++) begin
            @(negedge clk);
            if (out_valid) begin
                v = int'(out_data);
                l = int'(out_len);
                break;
            end
        end
        if (w > 50) chk("out_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    initial begin : stim
        int v, l, w, b;
        bit ok;
        repeat (2) @(posedge clk); #1;
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_len", 32'(out_len), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_in_ready", 32'(in_ready), 1);
        reset_n = 1'b1;
        @(posedge clk); #1;

        push(16'h2800);
        chk("ue_fill_pre", 32'(fill_level), 16);
        req(EGD_UE, 1'b0, 5'd0);
        get_out(v, l, w);
        chk("ue_val", v, 4);
        chk("ue_len", l, 5);
        chk("ue_latency", w, 2);
        chk("ue_fill_post", 32'(fill_level), 11);
        do_flush();

        push(16'h2800);
        req(EGD_SE, 1'b0, 5'd0);
`ifdef EGD_SIGNED_EN
        get_out(v, l, w);
        chk("se_val", v, 32'hFFFE);
        chk("se_len", l, 5);
`else
        chk("se_rej_err", 32'(err), 1);
        chk("se_rej_in_ready", 32'(in_ready), 0);
        chk("se_rej_req_ready", 32'(req_ready), 0);
        chk("se_rej_fill", 32'(fill_level), 16);
`endif
        do_flush();

        push(16'hB000);
        req(EGD_RAW, 1'b0, 5'd4);
        get_out(v, l, w);
        chk("raw4_val", v, 11);
        chk("raw4_len", l, 4);
        req(EGD_TE, 1'b1, 5'd0);
`ifdef EGD_SIGNED_EN
        get_out(v, l, w);
        chk("te1_val", v, 1);
        chk("te1_len", l, 1);
`else
        chk("te_rej_err", 32'(err), 1);
`endif
        do_flush();

        push(16'h0000);
        push(16'h8000);
        req(EGD_UE, 1'b0, 5'd0);
        for (w = 0; w < 20; w++) begin
            @(negedge clk);
            if (err) break;
        end
        chk("lz_err", 32'(err), 1);
        chk("lz_err_in_ready", 32'(in_ready), 0);
        chk("lz_err_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        do_flush();
        chk("flush_err", 32'(err), 0);
        chk("flush_fill", 32'(fill_level), 0);

        out_ready = 1'b0;
        push(16'hA000);
        req(EGD_UE, 1'b0, 5'd0);
        req(EGD_UE, 1'b0, 5'd0);
        get_out(v, l, w);
        chk("held_val", v, 0);
        chk("held_len", l, 1);
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (!(out_valid && out_data == 16'd0 && out_len == 6'd1)) ok = 1'b0;
        end
        chk("held_stable", 32'(ok), 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        get_out(v, l, w);
        chk("second_val", v, 1);
        chk("second_len", l, 3);
        chk("second_fill", 32'(fill_level), 12);
        do_flush();

        push(16'hA000);
        req(EGD_RAW, 1'b0, 5'd9);
        get_out(v, l, w);
        chk("raw9_val", v, 32'h140);
        chk("raw9_len", l, 9);
        req(EGD_RAW, 1'b0, 5'd16);
        chk("wait_fill", 32'(fill_level), 7);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_fill", 32'(fill_level), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_data", 32'(out_data), 0);
        chk("arst_out_len", 32'(out_len), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_req_ready", 32'(req_ready), 1);
        chk("arst_in_ready", 32'(in_ready), 1);
        #3 reset_n = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) ok = 1'b0;
        end
        chk("no_stray_out", 32'(ok), 1);
        @(posedge clk); #1;

        mon_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 3) != 0;
            in_data   = gen_word();
            req_valid = $urandom % 2;
`ifdef EGD_SIGNED_EN
            req_mode  = 2'($urandom_range(0, 3));
`else
            req_mode  = ($urandom % 2) ? EGD_RAW : EGD_UE;
`endif
            req_te_max1 = $urandom % 2;
            req_len     = 5'($urandom_range(1, 16));
            out_ready   = ($urandom % 4) != 0;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        out_ready = 1'b1;
        b = 0;
        while (reqq.size() > 0 && b < 1000) begin
            in_valid = 1'b1;
            in_data  = gen_word();
            @(posedge clk); #1;
            b++;
        end
        in_valid = 1'b0;
        chk("drain_done", reqq.size(), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("end_fill", 32'(fill_level), bitq.size());
        chk("end_err", 32'(err), 0);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
